// File: rtl/lsu_sequencer_if.sv
// Request/acknowledge memory port between the load/store sequencer and memory.
// The master holds a request stable until the slave acknowledges it; rdata is valid with ack.
interface lsu_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_size, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_size, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_sequencer.sv
// Serializes one bundle's load/store slots in slot order onto a req/ack port; first request 1 cycle after capture,
// writeback 1 cycle after ack. Memory backpressures by delaying ack; busy holds off issue until the bundle drains.
module lsu_sequencer #(
    parameter int REG_IDX_W = 6
) (
    input  logic                 wb_clk_i,
    input  logic                 rst,
    input  logic                 issue,
    input  logic                 is_load0,
    input  logic                 is_load1,
    input  logic                 is_load2,
    input  logic                 is_store0,
    input  logic                 is_store1,
    input  logic                 is_store2,
    input  logic                 sign_extend0,
    input  logic                 sign_extend1,
    input  logic                 sign_extend2,
    input  logic [1:0]           loadstore_size0,
    input  logic [1:0]           loadstore_size1,
    input  logic [1:0]           loadstore_size2,
    input  logic [31:0]          loadstore_address0,
    input  logic [31:0]          loadstore_address1,
    input  logic [31:0]          loadstore_address2,
    input  logic [REG_IDX_W-1:0] loadstore_dest0,
    input  logic [REG_IDX_W-1:0] loadstore_dest1,
    input  logic [REG_IDX_W-1:0] loadstore_dest2,
    input  logic [31:0]          store_data0,
    input  logic [31:0]          store_data1,
    input  logic [31:0]          store_data2,
    output logic                 busy,
    lsu_sequencer_if.master      mem,
    output logic                 wb_valid,
    output logic [REG_IDX_W-1:0] wb_idx,
    output logic [31:0]          wb_val
);

    typedef enum logic {IDLE, REQ} state_t;

    typedef struct packed {
        logic                 we;
        logic                 sext;
        logic [1:0]           size;
        logic [31:0]          addr;
        logic [REG_IDX_W-1:0] dest;
        logic [31:0]          wdata;
    } slot_t;

    state_t     state;
    slot_t      slots   [3];
    slot_t      in_slot [3];
    slot_t      nxt;
    logic [2:0] pending;
    logic [2:0] in_mask;
    logic [2:0] rest;
    logic [1:0] cur;

    function automatic logic [1:0] first_set(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    function automatic logic [31:0] trim(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'd0:    return {24'b0, d[7:0]};
            2'd1:    return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size, input logic sx);
        case (size)
            2'd0:    return {{24{sx & d[7]}}, d[7:0]};
            2'd1:    return {{16{sx & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    // A slot flagged as both load and store is a store: we follows is_store alone.
    always_comb begin
        in_slot[0] = '{we: is_store0, sext: sign_extend0, size: loadstore_size0, addr: loadstore_address0,
                       dest: loadstore_dest0, wdata: trim(store_data0, loadstore_size0)};
        in_slot[1] = '{we: is_store1, sext: sign_extend1, size: loadstore_size1, addr: loadstore_address1,
                       dest: loadstore_dest1, wdata: trim(store_data1, loadstore_size1)};
        in_slot[2] = '{we: is_store2, sext: sign_extend2, size: loadstore_size2, addr: loadstore_address2,
                       dest: loadstore_dest2, wdata: trim(store_data2, loadstore_size2)};
    end

    assign in_mask = {is_load2 | is_store2, is_load1 | is_store1, is_load0 | is_store0};
    assign rest    = pending & ~(3'b001 << cur);

    // Slot presented on the port after this edge: first of a new bundle, or next still pending.
    always_comb begin
        nxt = (state == IDLE) ? in_slot[first_set(in_mask)] : slots[first_set(rest)];
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            state         <= IDLE;
            pending       <= 3'b000;
            cur           <= 2'd0;
            busy          <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_size  <= 2'd0;
            mem.mem_wdata <= 32'd0;
            wb_valid      <= 1'b0;
            wb_idx        <= '0;
            wb_val        <= 32'd0;
            for (int k = 0; k < 3; k++) slots[k] <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue && in_mask != 3'b000) begin
                        for (int k = 0; k < 3; k++) slots[k] <= in_slot[k];
                        pending       <= in_mask;
                        cur           <= first_set(in_mask);
                        busy          <= 1'b1;
                        state         <= REQ;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= nxt.we;
                        mem.mem_addr  <= nxt.addr;
                        mem.mem_size  <= nxt.size;
                        mem.mem_wdata <= nxt.wdata;
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        if (!slots[cur].we) begin
                            wb_valid <= 1'b1;
                            wb_idx   <= slots[cur].dest;
                            wb_val   <= extend(mem.mem_rdata, slots[cur].size, slots[cur].sext);
                        end
                        pending <= rest;
                        if (rest != 3'b000) begin
                            cur           <= first_set(rest);
                            mem.mem_we    <= nxt.we;
                            mem.mem_addr  <= nxt.addr;
                            mem.mem_size  <= nxt.size;
                            mem.mem_wdata <= nxt.wdata;
                        end else begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            mem.mem_req <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
